// File: rtl/fetch1.sv
// Fetch stage 1: owns the fetch PC, resolves next-PC priority, holds a redirect
// that arrives during a stall, and flags misaligned fetch addresses to Fetch2.
package fetch1_pkg;

    localparam logic [5:0] ECODE_ADEF = 6'h08;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } btb_pre_t;

    typedef struct packed {
        logic [31:0] pc;
        btb_pre_t    btb_pre;
        logic        is_flush;
    } fetch1_fetch2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } excp_pass_t;

endpackage

module fetch1
    import fetch1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                is_stall,
    input  logic                is_flush,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         btb_pc,
    input  logic                btb_hit,
    input  logic [31:0]         btb_target,
    output logic                icache_req,
    output logic [31:0]         icache_addr,
    output fetch1_fetch2_pass_t pass_out,
    output excp_pass_t          excp_pass_out
);

    logic [31:0] pc_r;
    logic [31:0] pc_nxt;
    logic        pend_valid;
    logic        pend_valid_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nxt;
    logic        aligned;

    // Redirects only take effect through pc_r on the next edge; a redirect seen
    // while stalled is parked in pend_* so the stall can keep pc_r steady.
    always_comb begin
        pc_nxt         = pc_r + 32'd4;
        pend_valid_nxt = pend_valid;
        pend_pc_nxt    = pend_pc;
        if (!is_stall && redirect_valid) begin
            pc_nxt         = redirect_pc;
            pend_valid_nxt = 1'b0;
        end else if (!is_stall && pend_valid) begin
            pc_nxt         = pend_pc;
            pend_valid_nxt = 1'b0;
        end else if (is_stall) begin
            pc_nxt = pc_r;
            if (redirect_valid) begin
                pend_valid_nxt = 1'b1;
                pend_pc_nxt    = redirect_pc;
            end
        end else if (btb_hit) begin
            pc_nxt = btb_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= 32'd0;
        end else begin
            pc_r       <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            pend_pc    <= pend_pc_nxt;
        end
    end

    assign aligned     = (pc_r[1:0] == 2'b00);
    assign btb_pc      = pc_r;
    assign icache_addr = pc_r;

    // rst_n gates the outputs so nothing is requested and everything is killed while in reset.
    assign icache_req = rst_n & ~pend_valid & ~redirect_valid & aligned;

    always_comb begin
        pass_out.pc             = pc_r;
        pass_out.btb_pre.taken  = btb_hit;
        pass_out.btb_pre.target = btb_target;
        pass_out.is_flush       = ~rst_n | is_flush | redirect_valid | pend_valid;
    end

    always_comb begin
        excp_pass_out.valid = ~aligned;
        excp_pass_out.ecode = aligned ? 6'd0 : ECODE_ADEF;
        excp_pass_out.badv  = aligned ? 32'd0 : pc_r;
    end

endmodule

// File: tb/tb_fetch1.sv
// Directed bench for fetch1: reset, sequential fetch, BTB hit, stalled redirects,
// misalignment, PC wrap and asynchronous reset during a pending redirect.
module tb_fetch1;
    import fetch1_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic                clk;
    logic                rst_n;
    logic                is_stall;
    logic                is_flush;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic [31:0]         btb_pc;
    logic                btb_hit;
    logic [31:0]         btb_target;
    logic                icache_req;
    logic [31:0]         icache_addr;
    fetch1_fetch2_pass_t pass_out;
    excp_pass_t          excp_pass_out;

    int vectors;
    int miscompares;
    logic seen_3000;

    fetch1 #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .is_stall       (is_stall),
        .is_flush       (is_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .btb_pc         (btb_pc),
        .btb_hit        (btb_hit),
        .btb_target     (btb_target),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .pass_out       (pass_out),
        .excp_pass_out  (excp_pass_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (icache_req && icache_addr == 32'h1C00_3000) seen_3000 = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        check({tag, ".icache_addr"}, icache_addr, exp);
        check({tag, ".btb_pc"}, btb_pc, exp);
        check({tag, ".pass_pc"}, pass_out.pc, exp);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        seen_3000 = 1'b0;
        rst_n = 1'b0;
        is_stall = 1'b0;
        is_flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        btb_hit = 1'b0;
        btb_target = 32'd0;

        // Held in reset
        step();
        step();
        check_pc("rst", RST_PC);
        check("rst.req", {31'd0, icache_req}, 32'd0);
        check("rst.flush", {31'd0, pass_out.is_flush}, 32'd1);
        check("rst.excp", {31'd0, excp_pass_out.valid}, 32'd0);

        // Release and sequential fetch
        rst_n = 1'b1;
        #1;
        check_pc("seq0", 32'h1C00_0000);
        check("seq0.req", {31'd0, icache_req}, 32'd1);
        check("seq0.flush", {31'd0, pass_out.is_flush}, 32'd0);
        step();
        check_pc("seq1", 32'h1C00_0004);
        step();
        check_pc("seq2", 32'h1C00_0008);
        step();
        step();
        check_pc("seq4", 32'h1C00_0010);

        // BTB hit
        btb_hit = 1'b1;
        btb_target = 32'h1C00_0100;
        #1;
        check("hit.taken", {31'd0, pass_out.btb_pre.taken}, 32'd1);
        check("hit.target", pass_out.btb_pre.target, 32'h1C00_0100);
        step();
        btb_hit = 1'b0;
        btb_target = 32'd0;
        #1;
        check_pc("hit.next", 32'h1C00_0100);

        // Redirect during a two-cycle stall
        is_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C00_2000;
        #1;
        check_pc("stl.nocomb", 32'h1C00_0100);
        check("stl.flush0", {31'd0, pass_out.is_flush}, 32'd1);
        check("stl.req0", {31'd0, icache_req}, 32'd0);
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check_pc("stl.hold1", 32'h1C00_0100);
        check("stl.flush1", {31'd0, pass_out.is_flush}, 32'd1);
        step();
        check_pc("stl.hold2", 32'h1C00_0100);
        check("stl.flush2", {31'd0, pass_out.is_flush}, 32'd1);
        is_stall = 1'b0;
        step();
        check_pc("stl.redir", 32'h1C00_2000);
        check("stl.flush3", {31'd0, pass_out.is_flush}, 32'd0);
        check("stl.req3", {31'd0, icache_req}, 32'd1);

        // Two redirects during one stall: the newer one wins
        is_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C00_3000;
        step();
        redirect_pc = 32'h1C00_4000;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check_pc("two.hold", 32'h1C00_2000);
        is_stall = 1'b0;
        step();
        check_pc("two.redir", 32'h1C00_4000);
        step();
        check_pc("two.seq", 32'h1C00_4004);
        check("two.no3000", {31'd0, seen_3000}, 32'd0);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C00_0002;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check_pc("mis", 32'h1C00_0002);
        check("mis.valid", {31'd0, excp_pass_out.valid}, 32'd1);
        check("mis.ecode", {26'd0, excp_pass_out.ecode}, 32'h8);
        check("mis.badv", excp_pass_out.badv, 32'h1C00_0002);
        check("mis.req", {31'd0, icache_req}, 32'd0);
        step();
        check_pc("mis.adv", 32'h1C00_0006);
        check("mis.valid2", {31'd0, excp_pass_out.valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C00_0000;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check_pc("mis.fix", 32'h1C00_0000);
        check("mis.clr", {31'd0, excp_pass_out.valid}, 32'd0);
        check("mis.req2", {31'd0, icache_req}, 32'd1);

        // 32-bit wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check_pc("wrap.top", 32'hFFFF_FFFC);
        step();
        check_pc("wrap.zero", 32'h0000_0000);

        // Asynchronous reset with a pending redirect
        is_stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h1C00_5000;
        step();
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        #1;
        check("arst.pend", {31'd0, pass_out.is_flush}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_pc("arst", RST_PC);
        check("arst.req", {31'd0, icache_req}, 32'd0);
        check("arst.flush", {31'd0, pass_out.is_flush}, 32'd1);
        is_stall = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("arst.noflush", {31'd0, pass_out.is_flush}, 32'd0);
        check("arst.req2", {31'd0, icache_req}, 32'd1);
        step();
        check_pc("arst.seq", RST_PC + 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch1.md
FETCH1 -- requirements
Module: fetch1

Interface
REQ-001 Parameter RESET_PC, default 32'h1C00_0000, is the PC loaded on reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port is_stall, input, 1, pipeline stall from ctrl; holds PC.
REQ-006 Port is_flush, input, 1, flush from ctrl; marks the current fetch as killed.
REQ-007 Port redirect_valid, input, 1, backend redirect (branch mispredict or exception).
REQ-008 Port redirect_pc, input, 32, redirect target.
REQ-009 Port btb_pc, output, 32, lookup address, equal to pc_r.
REQ-010 Port btb_hit, input, 1, BTB predicts taken for btb_pc.
REQ-011 Port btb_target, input, 32, predicted target.
REQ-012 Port icache_req, output, 1, fetch request valid this cycle.
REQ-013 Port icache_addr, output, 32, fetch address, equal to pc_r.
REQ-014 Port pass_out, output, fetch1_fetch2_pass_t, carries pc, btb_pre {taken, target} and is_flush to Fetch2.
REQ-015 Port excp_pass_out, output, excp_pass_t, carries the fetch exception to Fetch2.

Function
REQ-016 pc_r is the current fetch PC; btb_pc, icache_addr and pass_out.pc SHALL equal pc_r combinationally.
REQ-017 Next-PC priority SHALL be evaluated in this order, first match wins:
- live redirect_valid (when not stalled) -> redirect_pc
- pending redirect (when not stalled) -> pend_pc
- is_stall -> hold pc_r
- btb_hit -> btb_target
- otherwise -> pc_r + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-018 When redirect_valid and is_stall are both high, the block SHALL latch pend_valid=1 and pend_pc=redirect_pc.
REQ-019 A newer redirect arriving while pend_valid=1 SHALL overwrite pend_pc.
REQ-020 pend_valid SHALL clear on the first non-stalled edge, when pc_r loads either pend_pc or a live redirect; a live redirect beats pend_pc.
REQ-021 pass_out.btb_pre.taken SHALL equal btb_hit and pass_out.btb_pre.target SHALL equal btb_target, both sampled for pc_r in the same cycle.
REQ-022 pass_out.is_flush SHALL be set as is_flush | redirect_valid | pend_valid, so that a wrong-path fetch is killed downstream.
REQ-023 If pc_r[1:0] != 0, excp_pass_out SHALL report valid with ecode ADEF and badv=pc_r, and icache_req SHALL be 0.
REQ-024 If pc_r is aligned, excp_pass_out.valid SHALL be 0.
REQ-025 icache_req SHALL be ~pend_valid & ~redirect_valid & aligned; is_stall SHALL NOT suppress icache_req, because the cache sees the same address again.
REQ-026 A misaligned pc_r SHALL still advance normally (btb/+4) until a redirect arrives; the block SHALL NOT self-halt.
REQ-027 There SHALL be no combinational path from redirect_valid to pc_r; the redirect affects pc_r one edge later.

Reset
REQ-028 While rst_n=0, the block SHALL hold pc_r=RESET_PC, pend_valid=0, pend_pc=0, icache_req=0 and pass_out.is_flush=1.
REQ-029 Reset assertion mid-operation SHALL discard any pending redirect immediately and asynchronously.
REQ-030 On the first rising edge after rst_n deasserts, the block SHALL issue a fetch at RESET_PC with icache_req=1 and is_flush=0 when no other inputs are active.

Verification
REQ-031 Reset release, no stall, btb_hit=0 for 3 cycles -> icache_addr = 1C00_0000, 1C00_0004, 1C00_0008.
REQ-032 pc_r=1C00_0010, btb_hit=1, btb_target=1C00_0100 -> next pc_r=1C00_0100; pass_out.btb_pre={1, 1C00_0100} in the hit cycle.
REQ-033 is_stall=1 for 2 cycles with redirect_valid pulsed to 1C00_2000 in the first cycle, then is_stall=0 -> pc_r holds, pass_out.is_flush=1 throughout, and pc_r=1C00_2000 on the first non-stalled edge.
REQ-034 Two redirects, 1C00_3000 then 1C00_4000, both during a stall -> pc_r=1C00_4000 after the stall; 1C00_3000 is never fetched.
REQ-035 redirect_pc=1C00_0002 -> excp ADEF with badv=1C00_0002 and icache_req=0; a following redirect to 1C00_0000 clears the exception.
REQ-036 pc_r=FFFF_FFFC with no hit -> pc_r=0000_0000; rst_n dropped during a pending redirect -> pc_r=RESET_PC and pend_valid=0 immediately.
